// File: rtl/fifo8way16.sv
// -----------------------------------------------------------------------------
// fifo8way16 - 8-entry x 16-bit synchronous FIFO with valid/ready handshakes.
//
// Eight 16-bit storage registers are written through an 8-way load demux that
// is steered by a 3-bit write pointer. They are read through an 8-way 16-bit
// mux (mux8way16) that is steered by a 3-bit read pointer. The read side is
// show-ahead: out_data always presents the head entry.
//
// Optional feature (build macro FIFO8WAY16_BYPASS_EN):
//   When the FIFO is EMPTY and in_valid=1, the word is presented on out_* in
//   the same cycle. If out_ready=1 as well, the word is consumed directly and
//   is never stored. Without the macro there is no combinational in->out path.
//
// Parameters:
//   ALMOST_FULL_LEVEL  almost_full asserts when count >= this value (1..8)
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   in_data      in   [15:0] write data
//   in_valid     in   producer offers in_data
//   in_ready     out  FIFO can accept (push = in_valid & in_ready)
//   out_data     out  [15:0] head-of-queue data, 0 when out_valid=0
//   out_valid    out  head entry valid
//   out_ready    in   consumer takes head (pop = out_valid & out_ready)
//   count        out  [3:0] occupancy 0..8
//   almost_full  out  count >= ALMOST_FULL_LEVEL
// -----------------------------------------------------------------------------
module fifo8way16 #(
   parameter int ALMOST_FULL_LEVEL = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  count,
   output logic        almost_full
);

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] PARTIAL = 2'd1;
   localparam logic [1:0] FULL    = 2'd2;

   localparam logic [3:0] AF_LEVEL = ALMOST_FULL_LEVEL[3:0];

   // 8-way 16-bit read mux
   function automatic logic [15:0] mux8way16(
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [15:0] c,
      input logic [15:0] d,
      input logic [15:0] e,
      input logic [15:0] f,
      input logic [15:0] g,
      input logic [15:0] h,
      input logic [2:0]  sel
   );
      logic [15:0] y;
      case (sel)
         3'd0:    y = a;
         3'd1:    y = b;
         3'd2:    y = c;
         3'd3:    y = d;
         3'd4:    y = e;
         3'd5:    y = f;
         3'd6:    y = g;
         3'd7:    y = h;
         default: y = 16'h0000;
      endcase
      return y;
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  state_next_s;
   logic [3:0]  count_r;
   logic [3:0]  count_next_s;
   logic [2:0]  wr_ptr_r;
   logic [2:0]  rd_ptr_r;
   logic [15:0] mem_r [0:7];
   logic        almost_full_r;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [15:0] out_data_s;
   logic [15:0] head_s;
   logic        bypass_s;
   logic        push_s;
   logic        pop_s;
   logic        wr_en_s;
   logic        rd_en_s;

   assign head_s = mux8way16(mem_r[0], mem_r[1], mem_r[2], mem_r[3],
                             mem_r[4], mem_r[5], mem_r[6], mem_r[7], rd_ptr_r);

   // Output decode: handshake flags and head data from the current state
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      out_data_s  = 16'h0000;
      bypass_s    = 1'b0;
      // in_ready ignores out_ready on purpose: no push-through when full
      if (!reset && (state_r != FULL)) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
`ifdef FIFO8WAY16_BYPASS_EN
      if (state_r != EMPTY) begin
         out_valid_s = 1'b1;
         out_data_s  = head_s;
      end else if (!reset && in_valid) begin
         // empty FIFO forwards the offered word straight to the consumer
         out_valid_s = 1'b1;
         out_data_s  = in_data;
         bypass_s    = out_ready;
      end else begin
         out_valid_s = 1'b0;
         out_data_s  = 16'h0000;
      end
`else
      if (state_r != EMPTY) begin
         out_valid_s = 1'b1;
         out_data_s  = head_s;
      end else begin
         out_valid_s = 1'b0;
         out_data_s  = 16'h0000;
      end
`endif
   end

   assign push_s  = in_valid & in_ready_s;
   assign pop_s   = out_valid_s & out_ready;
   // a bypassed word touches neither storage, pointers nor count
   assign wr_en_s = push_s & ~bypass_s;
   assign rd_en_s = pop_s & ~bypass_s;

   // Next-state decode: occupancy and state follow the accepted transfers
   always_comb begin
      count_next_s = count_r;
      state_next_s = state_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_next_s = count_r + 4'd1;
         2'b01:   count_next_s = count_r - 4'd1;
         default: count_next_s = count_r;
      endcase
      // state is derived from the next count so the two can never disagree
      if (count_next_s == 4'd0) begin
         state_next_s = EMPTY;
      end else if (count_next_s == 4'd8) begin
         state_next_s = FULL;
      end else begin
         state_next_s = PARTIAL;
      end
   end

   // State register: FSM state, occupancy and almost_full flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= EMPTY;
         count_r       <= 4'd0;
         almost_full_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         count_r       <= count_next_s;
         almost_full_r <= (count_next_s >= AF_LEVEL);
      end
   end

   // Pointers and storage: demuxed write into mem_r, pointers wrap mod 8
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= 3'd0;
         rd_ptr_r <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
            wr_ptr_r        <= wr_ptr_r + 3'd1;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + 3'd1;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_s;
   assign out_data    = out_data_s;
   assign count       = count_r;
   assign almost_full = almost_full_r;

endmodule
